button_bank: RTL and testbench

BUTTON_BANK -- requirements
Module: button_bank

---
 rtl/button_bank.sv | 161 ++++++++++++++++
 tb/tb_button_bank.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/button_bank.sv
// ============================================================================
// button_bank : per-channel synchronise, debounce, press/release/long/repeat
// Revision    : 1.0
// ============================================================================
`default_nettype none

module button_bank #(
  parameter int CHANNELS        = 4,
  parameter bit ACTIVE_STATE    = 1'b1,
  parameter int CLOCKS_PER_USEC = 100,
  parameter int DEBOUNCE_MSEC   = 10,
  parameter int LONG_PRESS_MSEC = 1000,
  parameter int REPEAT_MSEC     = 0
) (
  input  logic                CLK,
  input  logic                RESETN,
  input  logic [CHANNELS-1:0] PIN,
  output logic [CHANNELS-1:0] STATE,
  output logic [CHANNELS-1:0] PRESS,
  output logic [CHANNELS-1:0] RELEASE,
  output logic [CHANNELS-1:0] LONG_PRESS,
  output logic [CHANNELS-1:0] REPEAT,
  output logic                ANY_PRESS
);

  localparam int DEBOUNCE_PERIOD = CLOCKS_PER_USEC * DEBOUNCE_MSEC * 1000;
  localparam int LONG_PERIOD     = CLOCKS_PER_USEC * LONG_PRESS_MSEC * 1000;
  localparam int REPEAT_PERIOD   = CLOCKS_PER_USEC * REPEAT_MSEC * 1000;
  localparam bit LONG_EN         = (LONG_PERIOD > 0);
  localparam bit REPEAT_EN       = LONG_EN && (REPEAT_PERIOD > 0);

  localparam int DB_W   = (DEBOUNCE_PERIOD > 0) ? $clog2(DEBOUNCE_PERIOD + 1) : 1;
  localparam int HOLD_W = (LONG_PERIOD > 0)     ? $clog2(LONG_PERIOD + 1)     : 1;
  localparam int REP_W  = (REPEAT_PERIOD > 0)   ? $clog2(REPEAT_PERIOD + 1)   : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } chan_state_e;

  logic [CHANNELS-1:0] sync1_q;
  logic [CHANNELS-1:0] sync2_q;
  logic [CHANNELS-1:0] sync3_unused_q;
  logic [CHANNELS-1:0] sample;

  // Stage 2 feeds the debouncer; stage 3 is a settling tap with no fan-out.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      sync1_q        <= {CHANNELS{~ACTIVE_STATE}};
      sync2_q        <= {CHANNELS{~ACTIVE_STATE}};
      sync3_unused_q <= {CHANNELS{~ACTIVE_STATE}};
    end else begin
      sync1_q        <= PIN;
      sync2_q        <= sync1_q;
      sync3_unused_q <= sync2_q;
    end
  end

  assign sample = ACTIVE_STATE ? sync2_q : ~sync2_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    chan_state_e       fsm_q;
    logic [DB_W-1:0]   db_q;
    logic [HOLD_W-1:0] hold_q;
    logic [REP_W-1:0]  rep_q;
    logic              lvl_q;
    logic              press_q;
    logic              release_q;
    logic              long_q;
    logic              repeat_q;
    logic              differ;
    logic              toggle;
    logic              rise;
    logic              fall;

    assign differ = sample[i] ^ lvl_q;
    assign toggle = differ && (db_q == DB_W'(DEBOUNCE_PERIOD - 1));
    assign rise   = toggle & ~lvl_q;
    assign fall   = toggle &  lvl_q;

    always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
        fsm_q     <= IDLE;
        db_q      <= '0;
        hold_q    <= '0;
        rep_q     <= '0;
        lvl_q     <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        repeat_q  <= 1'b0;
      end else begin
        press_q   <= rise;
        release_q <= fall;
        long_q    <= 1'b0;
        repeat_q  <= 1'b0;

        if (!differ) begin
          db_q <= '0;
        end else if (toggle) begin
          db_q  <= '0;
          lvl_q <= sample[i];
        end else begin
          db_q <= db_q + 1'b1;
        end

        // A release on the same edge as a due long/repeat pulse suppresses it.
        case (fsm_q)
          IDLE: begin
            hold_q <= '0;
            rep_q  <= '0;
            if (rise) fsm_q <= HELD;
          end
          HELD: begin
            if (fall) begin
              fsm_q  <= IDLE;
              hold_q <= '0;
              rep_q  <= '0;
            end else if (LONG_EN && (hold_q == HOLD_W'(LONG_PERIOD - 1))) begin
              fsm_q  <= LONG;
              long_q <= 1'b1;
              hold_q <= HOLD_W'(LONG_PERIOD);
              rep_q  <= '0;
            end else if (LONG_EN) begin
              hold_q <= hold_q + 1'b1;
            end
          end
          LONG: begin
            if (fall) begin
              fsm_q  <= IDLE;
              hold_q <= '0;
              rep_q  <= '0;
            end else if (REPEAT_EN && (rep_q == REP_W'(REPEAT_PERIOD - 1))) begin
              repeat_q <= 1'b1;
              rep_q    <= '0;
            end else if (REPEAT_EN) begin
              rep_q <= rep_q + 1'b1;
            end
          end
          default: begin
            fsm_q  <= IDLE;
            hold_q <= '0;
            rep_q  <= '0;
          end
        endcase
      end
    end

    assign STATE[i]      = lvl_q;
    assign PRESS[i]      = press_q;
    assign RELEASE[i]    = release_q;
    assign LONG_PRESS[i] = long_q;
    assign REPEAT[i]     = repeat_q;
  end

  assign ANY_PRESS = |PRESS;

endmodule

`default_nettype wire

// File: tb/tb_button_bank.sv
// ============================================================================
// tb_button_bank : directed self-checking bench for button_bank
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_button_bank;

  logic       CLK;
  logic       RESETN;
  logic [3:0] PIN;
  logic [3:0] STATE;
  logic [3:0] PRESS;
  logic [3:0] RELEASE;
  logic [3:0] LONG_PRESS;
  logic [3:0] REPEAT;
  logic       ANY_PRESS;

  int n_checks;
  int n_errors;

  // Per-watch event log for one channel; index 0..3 = press, release, long, repeat
  int         w_first [4];
  int         w_last  [4];
  int         w_cnt   [4];
  logic [3:0] w_pvec;
  logic       w_any;
  logic       w_state;

  button_bank #(
    .CHANNELS        (4),
    .ACTIVE_STATE    (1'b1),
    .CLOCKS_PER_USEC (1),
    .DEBOUNCE_MSEC   (1),
    .LONG_PRESS_MSEC (3),
    .REPEAT_MSEC     (1)
  ) dut (
    .CLK        (CLK),
    .RESETN     (RESETN),
    .PIN        (PIN),
    .STATE      (STATE),
    .PRESS      (PRESS),
    .RELEASE    (RELEASE),
    .LONG_PRESS (LONG_PRESS),
    .REPEAT     (REPEAT),
    .ANY_PRESS  (ANY_PRESS)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Runs n cycles, logging on which cycle (1-based) each pulse of channel ch appears.
  task automatic watch(input int n, input int ch);
    logic [3:0] evt;
    for (int k = 0; k < 4; k++) begin
      w_first[k] = 0;
      w_last[k]  = 0;
      w_cnt[k]   = 0;
    end
    w_pvec  = '0;
    w_any   = 1'b0;
    w_state = 1'b0;
    for (int i = 1; i <= n; i++) begin
      tick();
      evt = {REPEAT[ch], LONG_PRESS[ch], RELEASE[ch], PRESS[ch]};
      for (int k = 0; k < 4; k++) begin
        if (evt[k]) begin
          if (w_cnt[k] == 0) begin
            w_first[k] = i;
            if (k == 0) begin
              w_pvec  = PRESS;
              w_any   = ANY_PRESS;
              w_state = STATE[ch];
            end
          end
          w_last[k] = i;
          w_cnt[k]++;
        end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    RESETN   = 1'b1;
    PIN      = 4'b0000;
    #1 RESETN = 1'b0;
    #1;
    check("rst_state",   STATE,      4'b0000);
    check("rst_press",   PRESS,      4'b0000);
    check("rst_release", RELEASE,    4'b0000);
    check("rst_long",    LONG_PRESS, 4'b0000);
    check("rst_repeat",  REPEAT,     4'b0000);
    check("rst_any",     ANY_PRESS,  1'b0);
    repeat (3) tick();
    #3 RESETN = 1'b1;

    // Channel 0: clean press then release
    PIN[0] = 1'b1;
    watch(1005, 0);
    check("c0_press_at",    w_first[0], 1002);
    check("c0_press_cnt",   w_cnt[0],   1);
    check("c0_press_any",   w_any,      1'b1);
    check("c0_press_state", w_state,    1'b1);
    check("c0_press_vec",   w_pvec,     4'b0001);
    PIN[0] = 1'b0;
    watch(1005, 0);
    check("c0_rel_at",   w_first[1], 1002);
    check("c0_rel_cnt",  w_cnt[1],   1);
    check("c0_long_cnt", w_cnt[2],   0);
    check("c0_state_lo", STATE[0],   1'b0);

    // Channel 1: one-cycle dropout just before debounce completes
    PIN[1] = 1'b1;
    watch(999, 1);
    check("c1_pre_glitch", w_cnt[0], 0);
    PIN[1] = 1'b0;
    watch(1, 1);
    check("c1_glitch", w_cnt[0], 0);
    PIN[1] = 1'b1;
    watch(1005, 1);
    check("c1_press_at",  w_first[0], 1002);
    check("c1_press_cnt", w_cnt[0],   1);
    PIN[1] = 1'b0;
    watch(1005, 1);
    check("c1_rel_at", w_first[1], 1002);

    // Channel 2: long press and auto-repeat
    PIN[2] = 1'b1;
    watch(6007, 2);
    check("c2_press_at",   w_first[0], 1002);
    check("c2_long_at",    w_first[2], 4002);
    check("c2_long_cnt",   w_cnt[2],   1);
    check("c2_rep_first",  w_first[3], 5002);
    check("c2_rep_last",   w_last[3],  6002);
    check("c2_rep_cnt",    w_cnt[3],   2);
    PIN[2] = 1'b0;
    watch(2000, 2);
    check("c2_rep_tail_at",  w_first[3], 995);
    check("c2_rep_tail_cnt", w_cnt[3],   1);
    check("c2_rel_at",       w_first[1], 1002);
    check("c2_long_after",   w_cnt[2],   0);

    // Channel 3: release lands on the very edge the long press would fire
    PIN[3] = 1'b1;
    watch(3000, 3);
    check("c3_press_at", w_first[0], 1002);
    check("c3_long_pre", w_cnt[2],   0);
    PIN[3] = 1'b0;
    watch(2500, 3);
    check("c3_rel_at",   w_first[1], 1002);
    check("c3_long_cnt", w_cnt[2],   0);
    check("c3_rep_cnt",  w_cnt[3],   0);
    check("c3_state_lo", STATE[3],   1'b0);

    // All channels together, then reset mid-hold with pins still active
    PIN = 4'b1111;
    watch(2502, 0);
    check("all_press_at",  w_first[0], 1002);
    check("all_press_vec", w_pvec,     4'b1111);
    check("all_press_any", w_any,      1'b1);
    check("all_state",     STATE,      4'b1111);
    #3 RESETN = 1'b0;
    #1;
    check("mid_rst_state", STATE,     4'b0000);
    check("mid_rst_any",   ANY_PRESS, 1'b0);
    check("mid_rst_long",  LONG_PRESS, 4'b0000);
    repeat (2) tick();
    #3 RESETN = 1'b1;
    watch(1005, 0);
    check("post_rst_press_at",  w_first[0], 1002);
    check("post_rst_press_vec", w_pvec,     4'b1111);
    check("post_rst_press_cnt", w_cnt[0],   1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
